reg_file_rename: RTL and testbench

//  Architectural register file with per-register rename tags. Sits downstream of the ROB commit port and beside the dispatcher.

---
 rtl/reg_file_rename_pkg.sv | 19 +
 rtl/reg_file_rename_read_port.sv | 49 ++++
 rtl/reg_file_rename.sv | 90 +++++++++
 tb/tb_reg_file_rename.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_rename_pkg.sv
// rtl/reg_file_rename_pkg.sv - shared constants for the renaming register file
//
// Purpose: sizes and named constants used by reg_file_rename and rf_read_port.
//   NREG     architectural registers (x0 hard-wired to zero)
//   XLEN     data width
//   ROB_ID_W ROB id width; id 0 means "not renamed"
package reg_file_rename_pkg;

    localparam int NREG     = 32;
    localparam int XLEN     = 32;
    localparam int ROB_ID_W = 4;
    localparam int REG_W    = 5;

    localparam logic [REG_W-1:0]    REG_ZERO     = '0;
    localparam logic [ROB_ID_W-1:0] RENAMED_ZERO = '0;
    localparam logic                TRUE         = 1'b1;
    localparam logic                FALSE        = 1'b0;

endpackage

// File: rtl/reg_file_rename_read_port.sv
// rtl/reg_file_rename_read_port.sv - one combinational source-operand query with commit forwarding
//
// Purpose: resolves one source register to either a committed value or the
// ROB id that will produce it.
// Ports:
//   idx          in   queried register index
//   tag          in   current rename tag of that register
//   val_in       in   current committed value of that register
//   commit_*     in   commit presented this cycle (forwarded when it retires the tag)
//   busy         out  1 = value pending on alias_id
//   alias_id     out  producing ROB id, 0 when not busy
//   val_out      out  committed or forwarded value, 0 for x0
module rf_read_port
    import reg_file_rename_pkg::*;
(
    input  logic [REG_W-1:0]    idx,
    input  logic [ROB_ID_W-1:0] tag,
    input  logic [XLEN-1:0]     val_in,
    input  logic                commit_ena,
    input  logic [REG_W-1:0]    commit_rd,
    input  logic [XLEN-1:0]     commit_val,
    input  logic [ROB_ID_W-1:0] commit_alias,
    output logic                busy,
    output logic [ROB_ID_W-1:0] alias_id,
    output logic [XLEN-1:0]     val_out
);

    // The commit retires exactly the producer this register is waiting on,
    // so the consumer can take the value now instead of waiting a cycle.
    logic fwd;
    assign fwd = commit_ena && (commit_rd == idx) &&
                 (tag != RENAMED_ZERO) && (tag == commit_alias);

    always_comb begin
        busy     = FALSE;
        alias_id = RENAMED_ZERO;
        val_out  = '0;
        if (idx == REG_ZERO) begin
            busy     = FALSE;
        end else if (fwd) begin
            val_out  = commit_val;
        end else begin
            busy     = (tag != RENAMED_ZERO);
            alias_id = tag;
            val_out  = val_in;
        end
    end

endmodule

// File: rtl/reg_file_rename.sv
// rtl/reg_file_rename.sv - architectural register file with per-register rename tags
//
// Purpose: holds committed values and rename tags; answers two source queries
// combinationally; applies ROB commits, dispatcher renames and rollback flushes.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rdy                   global enable, low holds all state
//   rollback              clears every rename tag
//   rename_ena/rd/id      map rd to a new ROB id
//   rs1_idx, rs2_idx      source queries
//   rsN_busy/alias/val    query results
//   commit_ena/rd/val/alias  ROB commit write
module reg_file_rename
    import reg_file_rename_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                rename_ena,
    input  logic [REG_W-1:0]    rename_rd,
    input  logic [ROB_ID_W-1:0] rename_id,
    input  logic [REG_W-1:0]    rs1_idx,
    input  logic [REG_W-1:0]    rs2_idx,
    output logic                rs1_busy,
    output logic [ROB_ID_W-1:0] rs1_alias,
    output logic [XLEN-1:0]     rs1_val,
    output logic                rs2_busy,
    output logic [ROB_ID_W-1:0] rs2_alias,
    output logic [XLEN-1:0]     rs2_val,
    input  logic                commit_ena,
    input  logic [REG_W-1:0]    commit_rd,
    input  logic [XLEN-1:0]     commit_val,
    input  logic [ROB_ID_W-1:0] commit_alias
);

    logic [XLEN-1:0]     val_q [NREG];
    logic [ROB_ID_W-1:0] tag_q [NREG];

    // Later assignments override earlier ones: a commit clears a matching tag,
    // then a rollback clears all tags, otherwise a rename installs the new id.
    // x0 is never written so it stays zero from reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= RENAMED_ZERO;
            end
        end else if (rdy) begin
            if (commit_ena && commit_rd != REG_ZERO) begin
                val_q[commit_rd] <= commit_val;
                if (tag_q[commit_rd] == commit_alias)
                    tag_q[commit_rd] <= RENAMED_ZERO;
            end
            if (rollback) begin
                for (int i = 0; i < NREG; i++)
                    tag_q[i] <= RENAMED_ZERO;
            end else if (rename_ena && rename_rd != REG_ZERO) begin
                tag_q[rename_rd] <= rename_id;
            end
        end
    end

    rf_read_port u_rs1 (
        .idx          (rs1_idx),
        .tag          (tag_q[rs1_idx]),
        .val_in       (val_q[rs1_idx]),
        .commit_ena   (commit_ena),
        .commit_rd    (commit_rd),
        .commit_val   (commit_val),
        .commit_alias (commit_alias),
        .busy         (rs1_busy),
        .alias_id     (rs1_alias),
        .val_out      (rs1_val)
    );

    rf_read_port u_rs2 (
        .idx          (rs2_idx),
        .tag          (tag_q[rs2_idx]),
        .val_in       (val_q[rs2_idx]),
        .commit_ena   (commit_ena),
        .commit_rd    (commit_rd),
        .commit_val   (commit_val),
        .commit_alias (commit_alias),
        .busy         (rs2_busy),
        .alias_id     (rs2_alias),
        .val_out      (rs2_val)
    );

endmodule

// File: tb/tb_reg_file_rename.sv
// tb/tb_reg_file_rename.sv - self-checking bench for reg_file_rename
module tb_reg_file_rename;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, rename_ena, commit_ena;
    logic [4:0]  rename_rd, rs1_idx, rs2_idx, commit_rd;
    logic [3:0]  rename_id, commit_alias;
    logic [31:0] commit_val;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_alias, rs2_alias;
    logic [31:0] rs1_val, rs2_val;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_val [32];
    logic [3:0]  m_tag [32];

    always #5 clk = ~clk;

    reg_file_rename dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .rollback     (rollback),
        .rename_ena   (rename_ena),
        .rename_rd    (rename_rd),
        .rename_id    (rename_id),
        .rs1_idx      (rs1_idx),
        .rs2_idx      (rs2_idx),
        .rs1_busy     (rs1_busy),
        .rs1_alias    (rs1_alias),
        .rs1_val      (rs1_val),
        .rs2_busy     (rs2_busy),
        .rs2_alias    (rs2_alias),
        .rs2_val      (rs2_val),
        .commit_ena   (commit_ena),
        .commit_rd    (commit_rd),
        .commit_val   (commit_val),
        .commit_alias (commit_alias)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference query: what a register reads as, given model state and this cycle's commit.
    function automatic void model_query(input logic [4:0] r, output logic b,
                                        output logic [3:0] a, output logic [31:0] v);
        b = 1'b0; a = 4'd0; v = 32'd0;
        if (r == 5'd0) return;
        if (commit_ena && commit_rd == r && m_tag[r] != 4'd0 && m_tag[r] == commit_alias) begin
            v = commit_val;
            return;
        end
        b = (m_tag[r] != 4'd0);
        a = m_tag[r];
        v = m_val[r];
    endfunction

    // Inputs are stable from the negedge to the next posedge: check outputs, then
    // advance the model by the state change the coming posedge must perform.
    always @(negedge clk) begin
        logic        eb;
        logic [3:0]  ea;
        logic [31:0] ev;
        if (!rst) begin
            if (rename_ena)
                assert (rename_id != 4'd0) else $error("rename_id 0 issued");
            model_query(rs1_idx, eb, ea, ev);
            chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, eb});
            chk("rs1_alias", {28'd0, rs1_alias}, {28'd0, ea});
            chk("rs1_val", rs1_val, ev);
            model_query(rs2_idx, eb, ea, ev);
            chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, eb});
            chk("rs2_alias", {28'd0, rs2_alias}, {28'd0, ea});
            chk("rs2_val", rs2_val, ev);
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_val[i] = '0; m_tag[i] = '0; end
        end else if (rdy) begin
            if (commit_ena && commit_rd != 5'd0) begin
                if (m_tag[commit_rd] == commit_alias) m_tag[commit_rd] = 4'd0;
                m_val[commit_rd] = commit_val;
            end
            if (rollback) begin
                for (int i = 0; i < 32; i++) m_tag[i] = 4'd0;
            end else if (rename_ena && rename_rd != 5'd0) begin
                m_tag[rename_rd] = rename_id;
            end
        end
    end

    task automatic idle();
        rdy = 1'b1; rollback = 1'b0; rename_ena = 1'b0; commit_ena = 1'b0;
        rename_rd = '0; rename_id = '0; commit_rd = '0; commit_val = '0; commit_alias = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] id);
        rename_ena = 1'b1; rename_rd = rd; rename_id = id;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] id);
        commit_ena = 1'b1; commit_rd = rd; commit_val = v; commit_alias = id;
    endtask

    initial begin
        idle();
        rst = 1'b1; rs1_idx = 5'd5; rs2_idx = 5'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state
        #2;
        chk("t1 rs1_busy", {31'd0, rs1_busy}, 32'd0);
        chk("t1 rs1_alias", {28'd0, rs1_alias}, 32'd0);
        chk("t1 rs1_val", rs1_val, 32'd0);
        chk("t1 rs2_busy", {31'd0, rs2_busy}, 32'd0);
        chk("t1 rs2_val", rs2_val, 32'd0);

        // 2: rename then commit
        rename(5'd3, 4'd4); tick();
        rs1_idx = 5'd3; #2;
        chk("t2 busy", {31'd0, rs1_busy}, 32'd1);
        chk("t2 alias", {28'd0, rs1_alias}, 32'd4);
        commit(5'd3, 32'hDEAD, 4'd4); tick(); #2;
        chk("t2 busy after commit", {31'd0, rs1_busy}, 32'd0);
        chk("t2 val after commit", rs1_val, 32'hDEAD);

        // 3: older commit leaves the younger tag in place
        rename(5'd3, 4'd4); tick();
        rename(5'd3, 4'd7); tick();
        commit(5'd3, 32'h11, 4'd4); tick(); #2;
        chk("t3 busy kept", {31'd0, rs1_busy}, 32'd1);
        chk("t3 alias kept", {28'd0, rs1_alias}, 32'd7);
        chk("t3 val old commit", rs1_val, 32'h11);
        commit(5'd3, 32'h22, 4'd7); tick(); #2;
        chk("t3 busy cleared", {31'd0, rs1_busy}, 32'd0);
        chk("t3 val", rs1_val, 32'h22);

        // 4: same-cycle forward
        rename(5'd8, 4'd2); tick();
        rs2_idx = 5'd8; commit(5'd8, 32'h55, 4'd2); #2;
        chk("t4 fwd busy", {31'd0, rs2_busy}, 32'd0);
        chk("t4 fwd alias", {28'd0, rs2_alias}, 32'd0);
        chk("t4 fwd val", rs2_val, 32'h55);
        tick();

        // 5: commit and rename same register, rename wins the tag
        commit(5'd9, 32'h77, 4'd3); rename(5'd9, 4'd5); tick();
        rs1_idx = 5'd9; #2;
        chk("t5 busy", {31'd0, rs1_busy}, 32'd1);
        chk("t5 alias", {28'd0, rs1_alias}, 32'd5);
        chk("t5 val", rs1_val, 32'h77);

        // 6: rollback with commit and ignored rename
        rename(5'd1, 4'd6); tick();
        rename(5'd2, 4'd3); tick();
        rename(5'd10, 4'd8); tick();
        rollback = 1'b1; commit(5'd1, 32'h40, 4'd6); rename(5'd2, 4'd9); tick();
        rs1_idx = 5'd1; rs2_idx = 5'd2; #2;
        chk("t6 x1 busy", {31'd0, rs1_busy}, 32'd0);
        chk("t6 x1 val", rs1_val, 32'h40);
        chk("t6 x2 busy", {31'd0, rs2_busy}, 32'd0);
        chk("t6 x2 alias", {28'd0, rs2_alias}, 32'd0);
        rs2_idx = 5'd10; #1;
        chk("t6 x10 busy", {31'd0, rs2_busy}, 32'd0);

        // 6b: rdy low holds everything
        rename(5'd2, 4'd5); tick();
        rdy = 1'b0; rollback = 1'b1; commit(5'd1, 32'h99, 4'd6); rename(5'd3, 4'd1); tick();
        rs1_idx = 5'd2; rs2_idx = 5'd1; #2;
        chk("t6b x2 busy", {31'd0, rs1_busy}, 32'd1);
        chk("t6b x2 alias", {28'd0, rs1_alias}, 32'd5);
        chk("t6b x1 val", rs2_val, 32'h40);
        rs1_idx = 5'd3; #1;
        chk("t6b x3 busy", {31'd0, rs1_busy}, 32'd0);

        // x0 writes dropped
        commit(5'd0, 32'hFFFF, 4'd0); rename(5'd0, 4'd3); tick();
        rs1_idx = 5'd0; #2;
        chk("x0 busy", {31'd0, rs1_busy}, 32'd0);
        chk("x0 val", rs1_val, 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [4:0] cr;
            rdy      = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 1) rename(5'($urandom_range(0, 7)), 4'($urandom_range(1, 15)));
            if ($urandom_range(0, 1) == 1) begin
                cr = 5'($urandom_range(0, 7));
                commit(cr, $urandom, ($urandom_range(0, 2) != 0) ? m_tag[cr] : 4'($urandom_range(0, 15)));
            end
            rs1_idx = 5'($urandom_range(0, 8));
            rs2_idx = ($urandom_range(0, 1) == 1) ? commit_rd : 5'($urandom_range(0, 31));
            tick();
        end

        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
